dmx_tx: RTL
===========

// Module: dmx_tx
// PURPOSE
//  DMX512 transmitter. Holds a 512-channel universe written over the CSR bus and, when
//  enabled, streams it continuously as DMX frames: BREAK, MAB, start code 0x00, slots 1..512.
//  Line format is 250 kbaud, 8N2, LSB first. Sits beside the DMX receiver on the CSR bus.
//  Drives the line driver pin directly.
// PARAMETERS
//  csr_addr   4'h0        CSR bank select, compared with csr_a[13:10]
//  clk_freq   100000000   sys_clk frequency in Hz
//  break_bits 23          BREAK length in bit times (23 x 4us = 92us, must be >= 22)
//  mab_bits   3           MAB length in bit times (3 x 4us = 12us, must be >= 2)
// PORTS
//  sys_clk  in   1   system clock
//  sys_rst  in   1   asynchronous reset, active-high
//  csr_a    in   14  CSR address; [13:10] bank, [9] control select, [8:0] channel index
//  csr_we   in   1   CSR write strobe
//  csr_di   in   32  CSR write data; [7:0] used for channels, [0] used for control
//  csr_do   out  32  CSR read data, registered; 0 when bank not selected in previous cycle
//  tx       out  1   DMX line output (1 = mark/idle)
// BEHAVIOUR
//  CSR:
//  - sel = csr_a[13:10]==csr_addr.
//  - csr_a[9]=0: channel RAM at csr_a[8:0]; the write sets slot csr_a[8:0]+1 to csr_di[7:0];
//    read returns {24'h0, value}.
//  - csr_a[9]=1: CTRL; bit0 = enable (R/W), bit1 = busy (RO, state!=IDLE).
//  - Read latency is 1 cycle, same as the receiver. Reset values: CTRL=0, csr_do=0, tx=1.
//  - RAM contents are not reset.
//  Timing:
//  - bit_div = clk_freq/250000 cycles per bit. A bit-tick counter reloads to bit_div-1 on
//    every state entry. It pulses tick when it reaches 0.
//  FSM (state, next on tick unless noted):
//  - IDLE: tx=1. If enable, go to BREAK, slot=0, bitcnt=break_bits-1.
//  - BREAK: tx=0. When bitcnt==0, go to MAB with bitcnt=mab_bits-1. Otherwise decrement.
//  - MAB: tx=1. When bitcnt==0, go to START and load shreg with 0x00 (start code).
//  - START: tx=0, then DATA with bitcnt=7.
//  - DATA: tx=shreg[0]; shift right each tick. When bitcnt==0, go to STOP with bitcnt=1.
//  - STOP: tx=1 for 2 bits.
//    - During the first stop bit, issue a RAM read of index slot (the next slot's data).
//      The data is valid the next cycle and is latched into the prefetch reg.
//    - At the end: if slot==512, go to BREAK if enable, else IDLE.
//    - Otherwise slot++, load shreg from prefetch, go to START.
//  - Slot counter is 10 bits, range 0..512, no wrap. Frame = break+mab+513*11 bit times.
//  - No inter-frame mark beyond MAB.
//  Boundary conditions:
//  - Enable cleared mid-frame: the current frame completes, then IDLE.
//  - Enable set during the last stop bit: it is honoured (sampled at the frame end).
//  - CSR write to a slot in the same cycle as its prefetch read: the old value is sent.
//    A later write goes out in the next frame.
//  - The CSR port has read priority on its own port. The TX port is a separate port, so
//    there is never a conflict.
//  - sys_rst mid-frame: tx=1 immediately (async), FSM returns to IDLE, enable=0.
// CONFIGURATION
//  DMX_TX_IRQ_EN defined:
//  - Adds output port irq (1 bit, reset 0).
//  - irq pulses high for exactly one cycle at the end of slot 512's second stop bit.
//  - CTRL bit2 is irq_en (R/W, reset 0). The pulse is gated by irq_en.
//  DMX_TX_IRQ_EN undefined:
//  - No irq port.
//  - CTRL bit2 reads 0 and ignores writes.
// STRUCTURE
//  - Shared package: FSM state encodings (IDLE, BREAK, MAB, START, DATA, STOP), SLOT_LAST=512,
//    CTRL bit positions, DMX_BAUD=250000.
//  - Channel store is the existing dual-port dmx_dpram (port 1 CSR, port 2 TX read-only).
//  - One natural sub-module: dmx_tx_baud (bit-tick counter with reload input).
// TESTING (clk_freq=100e6, so bit = 400 cycles)
//  - Reset, enable=0 -> tx=1 indefinitely, busy=0, csr_do=0.
//  - Enable=1 -> tx low for 9200 cycles, then high for 1200 cycles, then start code 0x00 framed
//    with 1 start + 8 data + 2 stop bits.
//  - Write ch0=0xA5, ch511=0x3C -> slot1 bits LSB first 1,0,1,0,0,1,0,1.
//    Slot 512 = 0x3C. Total frame = 2267600 cycles. The next BREAK starts immediately.
//  - Clear enable during slot 100 -> frame completes through slot 512, tx=1, busy=0,
//    no new BREAK.
//  - Assert sys_rst mid-DATA -> tx=1 in the same cycle, CTRL reads 0 after release.
//  - DMX_TX_IRQ_EN with irq_en=1 -> one 1-cycle irq per frame, aligned to the frame end.
//    With irq_en=0 -> no irq.
//  - Loopback into the DMX receiver -> all 512 received values match the written RAM.

Source files
------------

// File: rtl/dmx_tx_pkg.sv
// Shared definitions for the DMX512 transmitter: FSM encoding, frame constants, CTRL layout.
// Used by dmx_tx and dmx_tx_baud.
package dmx_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_BREAK,
        ST_MAB,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    localparam int         DMX_BAUD  = 250000;
    localparam logic [9:0] SLOT_LAST = 10'd512;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_BUSY   = 1;
    localparam int CTRL_IRQ_EN = 2;

    function automatic int bit_div(input int clk_freq);
        return clk_freq / DMX_BAUD;
    endfunction

endpackage

// File: rtl/dmx_dpram.sv
// Dual-port channel store: port 1 read/write for the CSR bus, port 2 read-only for the TX engine.
// Both ports read synchronously and return the old word on a same-cycle write.
module dmx_dpram #(
    parameter int depth = 9,
    parameter int width = 8
) (
    input  logic             sys_clk,
    input  logic [depth-1:0] p1_a,
    input  logic             p1_we,
    input  logic [width-1:0] p1_di,
    output logic [width-1:0] p1_do,
    input  logic [depth-1:0] p2_a,
    output logic [width-1:0] p2_do
);

    logic [width-1:0] mem [0:(1 << depth) - 1];

    // NOTE: the array has no reset; clearing it would prevent block-RAM inference and
    // software is expected to load the universe before enabling.
    always_ff @(posedge sys_clk) begin
        if (p1_we)
            mem[p1_a] <= p1_di;
        p1_do <= mem[p1_a];
        p2_do <= mem[p2_a];
    end

endmodule

// File: rtl/dmx_tx_baud.sv
// Bit-time generator: counts div-1 down to 0, pulses tick at 0 and wraps.
// reload holds the counter at the top so the first bit after a restart is full length.
module dmx_tx_baud #(
    parameter int div = 400
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic reload,
    output logic tick
);

    localparam int            CW  = (div > 1) ? $clog2(div) : 1;
    localparam logic [CW-1:0] TOP = CW'(div - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)
            cnt <= TOP;
        else if (reload || cnt == '0)
            cnt <= TOP;
        else
            cnt <= cnt - CW'(1);
    end

    assign tick = (cnt == '0);

endmodule

// File: rtl/dmx_tx.sv
// DMX512 transmitter: CSR-loaded 512-slot universe streamed as BREAK/MAB/start code/slots, 8N2.
// Optional macro DMX_TX_IRQ_EN adds an end-of-frame irq output and CTRL bit2 irq_en.
module dmx_tx
    import dmx_tx_pkg::*;
#(
    parameter logic [3:0] csr_addr   = 4'h0,
    parameter int         clk_freq   = 100000000,
    parameter int         break_bits = 23,
    parameter int         mab_bits   = 3
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic [13:0] csr_a,
    input  logic        csr_we,
    input  logic [31:0] csr_di,
    output logic [31:0] csr_do,
`ifdef DMX_TX_IRQ_EN
    output logic        irq,
`endif
    output logic        tx
);

    localparam int         BIT_DIV    = bit_div(clk_freq);
    localparam logic [7:0] BREAK_LAST = 8'(break_bits - 1);
    localparam logic [7:0] MAB_LAST   = 8'(mab_bits - 1);

    logic       sel;
    logic       ctrl_sel;
    logic       enable;
    logic       irq_en;
    logic       sel_q;
    logic       ctrl_sel_q;
    logic [2:0] ctrl_q;
    logic [2:0] ctrl_rd;
    logic [7:0] ram_csr_q;
    logic [7:0] ram_tx_q;
    logic       unused_di;

    tx_state_t  state;
    logic [9:0] slot;
    logic [7:0] bitcnt;
    logic [7:0] shreg;
    logic [7:0] prefetch;
    logic       rd_req;
    logic       rd_pend;
    logic       tick;
    logic       reload;
    logic       frame_end;

    assign sel       = (csr_a[13:10] == csr_addr);
    assign ctrl_sel  = csr_a[9];
    assign unused_di = ^csr_di[31:8];

    always_comb begin
        ctrl_rd              = '0;
        ctrl_rd[CTRL_EN]     = enable;
        ctrl_rd[CTRL_BUSY]   = (state != ST_IDLE);
        ctrl_rd[CTRL_IRQ_EN] = irq_en;
    end

    dmx_dpram #(
        .depth (9),
        .width (8)
    ) u_ram (
        .sys_clk (sys_clk),
        .p1_a    (csr_a[8:0]),
        .p1_we   (sel && !ctrl_sel && csr_we),
        .p1_di   (csr_di[7:0]),
        .p1_do   (ram_csr_q),
        .p2_a    (slot[8:0]),
        .p2_do   (ram_tx_q)
    );

    dmx_tx_baud #(
        .div (BIT_DIV)
    ) u_baud (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .reload  (reload),
        .tick    (tick)
    );

    // The counter idles at its top value; every other state entry coincides with a wrap.
    assign reload    = (state == ST_IDLE);
    assign frame_end = (state == ST_STOP) && tick && (bitcnt == 8'd0) && (slot == SLOT_LAST);
    assign rd_req    = (state == ST_STOP) && tick && (bitcnt == 8'd1) && (slot != SLOT_LAST);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            enable     <= 1'b0;
            sel_q      <= 1'b0;
            ctrl_sel_q <= 1'b0;
            ctrl_q     <= '0;
        end else begin
            sel_q      <= sel;
            ctrl_sel_q <= ctrl_sel;
            ctrl_q     <= ctrl_rd;
            if (sel && ctrl_sel && csr_we)
                enable <= csr_di[CTRL_EN];
        end
    end

    // Every term is a register, so the read data stays aligned with the 1-cycle RAM read.
    assign csr_do = !sel_q     ? 32'd0 :
                    ctrl_sel_q ? {29'd0, ctrl_q} :
                                 {24'd0, ram_csr_q};

`ifdef DMX_TX_IRQ_EN
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            irq_en <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (sel && ctrl_sel && csr_we)
                irq_en <= csr_di[CTRL_IRQ_EN];
            irq <= irq_en && frame_end;
        end
    end
`else
    assign irq_en = 1'b0;
`endif

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state    <= ST_IDLE;
            tx       <= 1'b1;
            slot     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            prefetch <= '0;
            rd_pend  <= 1'b0;
        end else begin
            rd_pend <= rd_req;
            if (rd_pend)
                prefetch <= ram_tx_q;

            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    if (enable) begin
                        state  <= ST_BREAK;
                        tx     <= 1'b0;
                        slot   <= '0;
                        bitcnt <= BREAK_LAST;
                    end
                end
                ST_BREAK: if (tick) begin
                    if (bitcnt == 8'd0) begin
                        state  <= ST_MAB;
                        tx     <= 1'b1;
                        bitcnt <= MAB_LAST;
                    end else begin
                        bitcnt <= bitcnt - 8'd1;
                    end
                end
                ST_MAB: if (tick) begin
                    if (bitcnt == 8'd0) begin
                        state <= ST_START;
                        tx    <= 1'b0;
                        shreg <= 8'h00;
                    end else begin
                        bitcnt <= bitcnt - 8'd1;
                    end
                end
                ST_START: if (tick) begin
                    state  <= ST_DATA;
                    tx     <= shreg[0];
                    shreg  <= shreg >> 1;
                    bitcnt <= 8'd7;
                end
                ST_DATA: if (tick) begin
                    if (bitcnt == 8'd0) begin
                        state  <= ST_STOP;
                        tx     <= 1'b1;
                        bitcnt <= 8'd1;
                    end else begin
                        tx     <= shreg[0];
                        shreg  <= shreg >> 1;
                        bitcnt <= bitcnt - 8'd1;
                    end
                end
                ST_STOP: if (tick) begin
                    if (bitcnt != 8'd0) begin
                        bitcnt <= bitcnt - 8'd1;
                    end else if (frame_end) begin
                        // Enable is sampled only here, so a cleared enable finishes the frame.
                        if (enable) begin
                            state  <= ST_BREAK;
                            tx     <= 1'b0;
                            slot   <= '0;
                            bitcnt <= BREAK_LAST;
                        end else begin
                            state <= ST_IDLE;
                            tx    <= 1'b1;
                        end
                    end else begin
                        state <= ST_START;
                        tx    <= 1'b0;
                        slot  <= slot + 10'd1;
                        shreg <= prefetch;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule
